// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel programmable clock divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clk_div_pkg;

    localparam int DIV_WIDTH = 19;
    localparam int unsigned DEF_DIV_RST = 2**18;

    typedef logic [DIV_WIDTH-1:0] div_t;

    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: free-running counter, active/shadow period, registered outputs.
// Latency: outputs registered, reflect the count held in the same cycle; loads apply at wrap.
// Backpressure: pending flag blocks further loads until the shadow period has applied.
module clk_div_chan #(
    parameter int          WIDTH   = 19,
    parameter int unsigned DEF_DIV = 2**18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_div,
    input  logic             sync,
    output logic             pending,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEF_DIV);
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO    = '0;

    logic [WIDTH-1:0] count, count_n;
    logic [WIDTH-1:0] per, per_n;
    logic [WIDTH-1:0] shadow, shadow_n;
    logic             pend, pend_n;
    logic             clk_out_n, tick_n;
    logic             boundary;

    // A stopped channel (P=0) treats every edge as a boundary so a new period starts at once.
    assign boundary = sync || (per == ZERO) || (count == per - ONE);

    always_comb begin
        count_n  = count;
        per_n    = per;
        shadow_n = shadow;
        pend_n   = pend;

        if (boundary) begin
            count_n = ZERO;
            if (pend) begin
                per_n  = shadow;
                pend_n = 1'b0;
            end
        end else begin
            count_n = count + ONE;
        end

        // The top only issues load while pend is clear, so this never collides with an apply.
        if (load) begin
            shadow_n = load_div;
            pend_n   = 1'b1;
        end
    end

    always_comb begin
        clk_out_n = 1'b0;
        tick_n    = 1'b0;
        if (per_n == ONE) begin
            clk_out_n = 1'b1;
            tick_n    = 1'b1;
        end else if (per_n != ZERO) begin
            clk_out_n = (count_n < (per_n >> 1));
            tick_n    = (count_n == per_n - ONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= ZERO;
            per     <= RST_DIV;
            shadow  <= ZERO;
            pend    <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            count   <= count_n;
            per     <= per_n;
            shadow  <= shadow_n;
            pend    <= pend_n;
            clk_out <= clk_out_n;
            tick    <= tick_n;
        end
    end

    assign pending = pend;

endmodule

// File: rtl/prog_clk_div.sv
// NCH-channel programmable clock divider; optional sync port under PROG_CLK_DIV_SYNC_EN.
// Latency: registered outputs; a loaded period starts 1..P cycles after acceptance.
// Backpressure: cfg_ready drops while the addressed channel still has a pending load.
module prog_clk_div
    import clk_div_pkg::*;
#(
    parameter int          NCH     = 4,
    parameter int          WIDTH   = 19,
    parameter int unsigned DEF_DIV = DEF_DIV_RST
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [ch_idx_w(NCH)-1:0]   cfg_ch,
    input  logic [WIDTH-1:0]           cfg_div,
`ifdef PROG_CLK_DIV_SYNC_EN
    input  logic                       sync,
`endif
    output logic [NCH-1:0]             cfg_pending,
    output logic [NCH-1:0]             clk_out,
    output logic [NCH-1:0]             tick
);

    localparam int CW = ch_idx_w(NCH);

    logic [NCH-1:0] sel;
    logic [NCH-1:0] load;
    logic           sync_all;

`ifdef PROG_CLK_DIV_SYNC_EN
    assign sync_all = sync;
`else
    assign sync_all = 1'b0;
`endif

    // Out-of-range channel indices select nothing, so they are accepted and dropped.
    assign cfg_ready = ~|(sel & cfg_pending);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        assign sel[i]  = (cfg_ch == CW'(i));
        assign load[i] = cfg_valid & cfg_ready & sel[i];

        clk_div_chan #(
            .WIDTH   (WIDTH),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load[i]),
            .load_div (cfg_div),
            .sync     (sync_all),
            .pending  (cfg_pending[i]),
            .clk_out  (clk_out[i]),
            .tick     (tick[i])
        );
    end

endmodule

// File: tb/tb_prog_clk_div.sv
// Directed table plus hand sequences for prog_clk_div (NCH=5, WIDTH=8, DEF_DIV=6).
module tb_prog_clk_div;

    localparam int NCH   = 5;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [2:0]       cfg_ch;
    logic [WIDTH-1:0] cfg_div;
    logic             sync;
    logic [NCH-1:0]   cfg_pending;
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   tick;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    prog_clk_div #(
        .NCH     (NCH),
        .WIDTH   (WIDTH),
        .DEF_DIV (6)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
`ifdef PROG_CLK_DIV_SYNC_EN
        .sync        (sync),
`endif
        .cfg_pending (cfg_pending),
        .clk_out     (clk_out),
        .tick        (tick)
    );

    typedef struct {
        logic           vld;
        logic [2:0]     ch;
        logic [7:0]     div;
        logic           rdy;
        logic [NCH-1:0] e_clk;
        logic [NCH-1:0] e_tick;
        logic [NCH-1:0] e_pend;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [2:0] ch, input logic [7:0] div, input string nm);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = div;
        #1;
        chk({nm, "_rdy"}, 32'(cfg_ready), 32'd1);
        step();
        cfg_valid = 1'b0;
        cfg_ch    = 3'd0;
    endtask

    task automatic add(input logic v, input logic [2:0] c, input logic [7:0] d, input logic r,
                       input logic [NCH-1:0] ec, input logic [NCH-1:0] et, input logic [NCH-1:0] ep);
        vec_t e;
        e.vld = v; e.ch = c; e.div = d; e.rdy = r;
        e.e_clk = ec; e.e_tick = et; e.e_pend = ep;
        tbl.push_back(e);
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = 3'd0;
        cfg_div   = '0;
        sync      = 1'b0;

        // Edges 1..12: all channels at DEF_DIV=6, counts 1,2,3,4,5,0 repeating.
        for (int r = 0; r < 2; r++) begin
            add(0, 0, 0, 1, 5'h1F, 5'h00, 5'h00);
            add(0, 0, 0, 1, 5'h1F, 5'h00, 5'h00);
            add(0, 0, 0, 1, 5'h00, 5'h00, 5'h00);
            add(0, 0, 0, 1, 5'h00, 5'h00, 5'h00);
            add(0, 0, 0, 1, 5'h00, 5'h1F, 5'h00);
            add(0, 0, 0, 1, 5'h1F, 5'h00, 5'h00);
        end
        add(0, 0, 0, 1, 5'h1F, 5'h00, 5'h00);  // 13
        add(0, 0, 0, 1, 5'h1F, 5'h00, 5'h00);  // 14
        add(1, 1, 5, 1, 5'h00, 5'h00, 5'h02);  // 15 ch1 P=5 at count 2
        add(1, 1, 3, 0, 5'h00, 5'h00, 5'h02);  // 16 ch1 stalled
        add(1, 2, 6, 1, 5'h00, 5'h1F, 5'h06);  // 17 ch2 loads same P
        add(0, 0, 0, 1, 5'h1F, 5'h00, 5'h00);  // 18 wrap: both apply
        add(0, 0, 0, 1, 5'h1F, 5'h00, 5'h00);  // 19
        add(0, 0, 0, 1, 5'h1D, 5'h00, 5'h00);  // 20
        add(0, 0, 0, 1, 5'h00, 5'h00, 5'h00);  // 21
        add(0, 0, 0, 1, 5'h00, 5'h02, 5'h00);  // 22
        add(0, 0, 0, 1, 5'h02, 5'h1D, 5'h00);  // 23
        add(0, 0, 0, 1, 5'h1F, 5'h00, 5'h00);  // 24
        add(1, 7, 2, 1, 5'h1D, 5'h00, 5'h00);  // 25 out-of-range channel
        add(0, 0, 0, 1, 5'h1D, 5'h00, 5'h00);  // 26
        add(0, 0, 0, 1, 5'h00, 5'h02, 5'h00);  // 27

        repeat (3) @(posedge clk);
        #1;
        chk("rst_clk", 32'(clk_out), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_pend", 32'(cfg_pending), 32'd0);
        chk("rst_rdy", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            cfg_valid = tbl[i].vld;
            cfg_ch    = tbl[i].ch;
            cfg_div   = tbl[i].div;
            #1;
            chk($sformatf("row%0d_rdy", i + 1), 32'(cfg_ready), 32'(tbl[i].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_clk", i + 1), 32'(clk_out), 32'(tbl[i].e_clk));
            chk($sformatf("row%0d_tick", i + 1), 32'(tick), 32'(tbl[i].e_tick));
            chk($sformatf("row%0d_pend", i + 1), 32'(cfg_pending), 32'(tbl[i].e_pend));
        end
        cfg_valid = 1'b0;
        cfg_ch    = 3'd0;

        // ch2 at count 3 of P=6: P=1 applies two edges after acceptance.
        do_load(3'd2, 8'd1, "p1");
        chk("p1_pend_a", 32'(cfg_pending[2]), 32'd1);
        chk("p1_tick_a", 32'(tick[2]), 32'd0);
        step();
        chk("p1_tick_b", 32'(tick[2]), 32'd1);
        chk("p1_clk_b", 32'(clk_out[2]), 32'd0);
        step();
        chk("p1_pend_c", 32'(cfg_pending[2]), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("p1_tick_%0d", k), 32'(tick[2]), 32'd1);
            chk($sformatf("p1_clk_%0d", k), 32'(clk_out[2]), 32'd1);
            step();
        end

        // P=0 from P=1: boundary every cycle, stops on the next edge.
        do_load(3'd2, 8'd0, "p0");
        chk("p0_pend", 32'(cfg_pending[2]), 32'd1);
        chk("p0_tick_a", 32'(tick[2]), 32'd1);
        step();
        chk("p0_pend_b", 32'(cfg_pending[2]), 32'd0);
        chk("p0_clk_b", 32'(clk_out[2]), 32'd0);
        chk("p0_tick_b", 32'(tick[2]), 32'd0);
        step();
        chk("p0_clk_c", 32'(clk_out[2]), 32'd0);
        chk("p0_tick_c", 32'(tick[2]), 32'd0);

        // P=4 from stopped: applies on the next edge, count restarts at 0.
        do_load(3'd2, 8'd4, "p4");
        chk("p4_pend", 32'(cfg_pending[2]), 32'd1);
        chk("p4_clk_a", 32'(clk_out[2]), 32'd0);
        begin
            logic [4:0] ec;
            logic [4:0] et;
            ec = 5'b10011;  // counts 0,1,2,3,0 -> bit k is cycle k
            et = 5'b01000;
            for (int k = 0; k < 5; k++) begin
                step();
                chk($sformatf("p4_clk_%0d", k), 32'(clk_out[2]), 32'(ec[k]));
                chk($sformatf("p4_tick_%0d", k), 32'(tick[2]), 32'(et[k]));
            end
        end
        chk("p4_pend_done", 32'(cfg_pending[2]), 32'd0);

        // Reset mid-period with ch3 pending discards the load.
        do_load(3'd3, 8'd3, "rst3");
        chk("rst3_pend", 32'(cfg_pending[3]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst3_clk", 32'(clk_out), 32'd0);
        chk("rst3_tick", 32'(tick), 32'd0);
        chk("rst3_pendclr", 32'(cfg_pending), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(); step(); step();
        chk("rst3_clk_e3", 32'(clk_out), 32'd0);
        step(); step();
        chk("rst3_tick_e5", 32'(tick), 32'h1F);

        // Acceptance on the wrap edge lands in S and stays pending.
        do_load(3'd0, 8'd4, "wrap");
        chk("wrap_pend", 32'(cfg_pending), 32'h01);
        chk("wrap_clk", 32'(clk_out), 32'h1F);
        step(); step();
`ifdef PROG_CLK_DIV_SYNC_EN
        sync      = 1'b1;
        cfg_valid = 1'b1;
        cfg_ch    = 3'd1;
        cfg_div   = 8'd2;
        #1;
        chk("sync_rdy", 32'(cfg_ready), 32'd1);
        step();
        sync      = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = 3'd0;
        chk("sync_clk", 32'(clk_out), 32'h1F);
        chk("sync_tick", 32'(tick), 32'd0);
        chk("sync_pend", 32'(cfg_pending), 32'h02);
        step(); step();
        chk("sync_clk_c2", 32'(clk_out), 32'h1E);
        chk("sync_pend_c2", 32'(cfg_pending), 32'h02);
`else
        step(); step(); step(); step();
        chk("nosync_pend", 32'(cfg_pending), 32'd0);
        chk("nosync_clk0", 32'(clk_out), 32'h1F);
        step(); step();
        chk("nosync_clk2", 32'(clk_out), 32'h1E);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
